// File: rtl/reg_write_arbiter.sv
// Single-port register-file write arbiter: CPU writeback, debug-host writes and a
// zero-fill sequence for R0..R7 share one registered LD_REG/DR/wr_data port.
module reg_write_arbiter (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        cpu_req,
    input  logic [2:0]  cpu_dr,
    input  logic [15:0] cpu_data,
    input  logic        dbg_req,
    input  logic [2:0]  dbg_dr,
    input  logic [15:0] dbg_data,
    input  logic        clr_start,
    output logic        LD_REG,
    output logic [2:0]  DR,
    output logic [15:0] wr_data,
    output logic        dbg_ack,
    output logic        cpu_stall,
    output logic        clr_busy,
    output logic        clr_done,
    output logic        fsm_state
);

    // Handshakes: cpu_req is a one-cycle offer accepted unless cpu_stall is high in
    // that cycle (then the CPU re-presents it); dbg_req is held with stable payload
    // until dbg_ack, which pulses together with the LD_REG of that debug write.
    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;
    typedef enum logic [1:0] {G_NONE, G_CPU, G_DBG, G_CLR} grant_t;

    state_t      state, state_n;
    grant_t      grant;
    logic [2:0]  clr_idx, clr_idx_n;
    logic [1:0]  wait_cnt, wait_cnt_n;
    logic        done_n;
    logic        dbg_ok;

    // The ack cycle still sees dbg_req high; masking it stops a second write.
    assign dbg_ok    = dbg_req && !dbg_ack;
    assign clr_busy  = (state == CLEAR);
    assign fsm_state = state;

    always_comb begin
        state_n    = state;
        clr_idx_n  = clr_idx;
        wait_cnt_n = wait_cnt;
        grant      = G_NONE;
        cpu_stall  = 1'b0;
        done_n     = 1'b0;
        case (state)
            IDLE: begin
                if (dbg_ok && wait_cnt == 2'd3) begin
                    grant     = G_DBG;
                    cpu_stall = cpu_req;
                end else if (cpu_req) begin
                    grant = G_CPU;
                end else if (dbg_ok) begin
                    grant = G_DBG;
                end
                if (grant == G_DBG || !dbg_req)
                    wait_cnt_n = 2'd0;
                else if (wait_cnt != 2'd3)
                    wait_cnt_n = wait_cnt + 2'd1;
                if (clr_start) begin
                    state_n   = CLEAR;
                    clr_idx_n = 3'd0;
                end
            end
            CLEAR: begin
                if (cpu_req) begin
                    grant = G_CPU;
                end else begin
                    grant     = G_CLR;
                    clr_idx_n = clr_idx + 3'd1;
                    if (clr_idx == 3'd7) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            clr_idx  <= 3'd0;
            wait_cnt <= 2'd0;
            LD_REG   <= 1'b0;
            DR       <= 3'd0;
            wr_data  <= 16'h0000;
            dbg_ack  <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            state    <= state_n;
            clr_idx  <= clr_idx_n;
            wait_cnt <= wait_cnt_n;
            LD_REG   <= (grant != G_NONE);
            dbg_ack  <= (grant == G_DBG);
            clr_done <= done_n;
            // DR/wr_data keep their last value when nothing is granted.
            case (grant)
                G_CPU: begin
                    DR      <= cpu_dr;
                    wr_data <= cpu_data;
                end
                G_DBG: begin
                    DR      <= dbg_dr;
                    wr_data <= dbg_data;
                end
                G_CLR: begin
                    DR      <= clr_idx;
                    wr_data <= 16'h0000;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed and randomized checks of reg_write_arbiter against a rule-level model
// with a write-port scoreboard.
module tb_reg_write_arbiter;

    // ---------------- clock / reset ----------------
    logic        Clk = 1'b0;
    logic        Reset;
    logic        cpu_req;
    logic [2:0]  cpu_dr;
    logic [15:0] cpu_data;
    logic        dbg_req;
    logic [2:0]  dbg_dr;
    logic [15:0] dbg_data;
    logic        clr_start;
    logic        LD_REG;
    logic [2:0]  DR;
    logic [15:0] wr_data;
    logic        dbg_ack;
    logic        cpu_stall;
    logic        clr_busy;
    logic        clr_done;
    logic        fsm_state;

    always #5 Clk = ~Clk;

    reg_write_arbiter dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_dr(cpu_dr), .cpu_data(cpu_data),
        .dbg_req(dbg_req), .dbg_dr(dbg_dr), .dbg_data(dbg_data),
        .clr_start(clr_start),
        .LD_REG(LD_REG), .DR(DR), .wr_data(wr_data),
        .dbg_ack(dbg_ack), .cpu_stall(cpu_stall),
        .clr_busy(clr_busy), .clr_done(clr_done), .fsm_state(fsm_state)
    );

    // ---------------- scoreboard / model state ----------------
    logic [18:0] exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    bit          m_clear;
    int          m_idx;
    int          m_wait;
    bit          m_ld, m_ack, m_done;
    logic [2:0]  m_dr;
    logic [15:0] m_data;

    int          wr_cnt, ack_cnt, busy_cnt, done_cnt;
    int          done_dr;
    bit          last_stall;
    int          wr_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clear = 0; m_idx = 0; m_wait = 0;
        m_ld = 0; m_ack = 0; m_done = 0;
        m_dr = '0; m_data = '0;
        exp_q.delete();
    endtask

    task automatic clear_counters();
        wr_cnt = 0; ack_cnt = 0; busy_cnt = 0; done_cnt = 0; done_dr = -1;
        wr_log.delete();
    endtask

    // One cycle of the arbitration rules: who gets the port, what the CPU sees.
    task automatic model_step(output bit stall);
        int   g;   // 0 none, 1 cpu, 2 debug, 3 clear
        bit   dbg_ok;
        logic [2:0]  ndr;
        logic [15:0] ndata;
        g = 0; stall = 0; ndr = m_dr; ndata = m_data;
        m_done = 0;
        if (!m_clear) begin
            dbg_ok = dbg_req && !m_ack;
            if (dbg_ok && m_wait == 3) begin g = 2; stall = cpu_req; end
            else if (cpu_req) g = 1;
            else if (dbg_ok) g = 2;
            if (g == 2 || !dbg_req) m_wait = 0;
            else m_wait = (m_wait < 3) ? m_wait + 1 : 3;
            if (clr_start) begin m_clear = 1; m_idx = 0; end
        end else begin
            if (cpu_req) g = 1;
            else begin
                g = 3;
                ndr = 3'(m_idx); ndata = 16'h0000;
                if (m_idx == 7) begin m_clear = 0; m_done = 1; end
                m_idx = (m_idx + 1) % 8;
            end
        end
        if (g == 1) begin ndr = cpu_dr; ndata = cpu_data; end
        if (g == 2) begin ndr = dbg_dr; ndata = dbg_data; end
        m_ld  = (g != 0);
        m_ack = (g == 2);
        m_dr = ndr; m_data = ndata;
        if (g != 0) exp_q.push_back({ndr, ndata});
    endtask

    // ---------------- driver ----------------
    // Starts at a falling edge with inputs already driven; ends at the next one.
    task automatic tick();
        bit   stall_exp;
        logic [18:0] exp_w;
        #1;
        model_step(stall_exp);
        chk("cpu_stall", {31'd0, cpu_stall}, {31'd0, stall_exp});
        last_stall = (cpu_stall === 1'b1);
        @(posedge Clk);
        #1;
        chk("ld_reg", {31'd0, LD_REG}, {31'd0, m_ld});
        if (m_ld) begin
            exp_w = exp_q.pop_front();
            chk("wr_port", {13'd0, DR, wr_data}, {13'd0, exp_w});
        end else begin
            chk("wr_hold", {13'd0, DR, wr_data}, {13'd0, m_dr, m_data});
        end
        chk("dbg_ack",   {31'd0, dbg_ack},   {31'd0, m_ack});
        chk("clr_done",  {31'd0, clr_done},  {31'd0, m_done});
        chk("clr_busy",  {31'd0, clr_busy},  {31'd0, m_clear});
        chk("fsm_state", {31'd0, fsm_state}, {31'd0, m_clear});
        if (LD_REG === 1'b1) begin wr_cnt++; wr_log.push_back(int'(DR)); end
        if (dbg_ack === 1'b1) ack_cnt++;
        if (clr_busy === 1'b1) busy_cnt++;
        if (clr_done === 1'b1) begin done_cnt++; done_dr = int'(DR); end
        @(negedge Clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ld"},    {31'd0, LD_REG},    32'd0);
        chk({tag, "_dr"},    {29'd0, DR},        32'd0);
        chk({tag, "_data"},  {16'd0, wr_data},   32'd0);
        chk({tag, "_ack"},   {31'd0, dbg_ack},   32'd0);
        chk({tag, "_done"},  {31'd0, clr_done},  32'd0);
        chk({tag, "_busy"},  {31'd0, clr_busy},  32'd0);
        chk({tag, "_stall"}, {31'd0, cpu_stall}, 32'd0);
        chk({tag, "_state"}, {31'd0, fsm_state}, 32'd0);
    endtask

    task automatic idle_inputs();
        cpu_req = 0; cpu_dr = '0; cpu_data = '0;
        dbg_req = 0; dbg_dr = '0; dbg_data = '0;
        clr_start = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit cpu_used;
        bit dbg_linger;
        int stall_at;
        int guard;

        idle_inputs();
        Reset = 1'b1;
        #2 Reset = 1'b0;
        #2 check_all_zero("reset");
        @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        clear_counters();
        tick();

        // CPU write appears one cycle later, once.
        cpu_req = 1; cpu_dr = 3'd3; cpu_data = 16'hBEEF;
        tick();
        chk("cpu_ld",   {31'd0, LD_REG},  32'd1);
        chk("cpu_dr",   {29'd0, DR},      32'd3);
        chk("cpu_data", {16'd0, wr_data}, 32'hBEEF);
        cpu_req = 0;
        tick();
        chk("cpu_ld_once", {31'd0, LD_REG}, 32'd0);

        // Debug write, request still high in the ack cycle.
        clear_counters();
        dbg_req = 1; dbg_dr = 3'd5; dbg_data = 16'h1234;
        tick();
        chk("dbg_dr",   {29'd0, DR},      32'd5);
        chk("dbg_data", {16'd0, wr_data}, 32'h1234);
        tick();
        dbg_req = 0;
        repeat (3) tick();
        chk("dbg_ack_count", ack_cnt, 32'd1);
        chk("dbg_wr_count",  wr_cnt,  32'd1);

        // Starvation: three CPU grants, then debug with a stall, then CPU again.
        clear_counters();
        stall_at = -1;
        cpu_req = 1; cpu_dr = 3'd1; cpu_data = 16'h1111;
        dbg_req = 1; dbg_dr = 3'd6; dbg_data = 16'h6666;
        for (int i = 0; i < 6; i++) begin
            if (m_ack) dbg_req = 0;
            tick();
            if (last_stall) stall_at = i;
        end
        chk("starve_stall_at", stall_at, 32'd3);
        chk("starve_acks",     ack_cnt,  32'd1);
        chk("starve_writes",   wr_cnt,   32'd6);
        chk("starve_log3",     wr_log[3], 32'd6);
        idle_inputs();
        tick();

        // Plain clear sequence.
        clear_counters();
        clr_start = 1;
        tick();
        clr_start = 0;
        repeat (10) tick();
        chk("clr_busy_cycles", busy_cnt, 32'd8);
        chk("clr_writes",      wr_cnt,   32'd8);
        chk("clr_done_count",  done_cnt, 32'd1);
        chk("clr_done_dr",     done_dr,  32'd7);
        for (int i = 0; i < wr_log.size(); i++) chk("clr_order", wr_log[i], i);

        // CPU interrupts the clear at index 4.
        clear_counters();
        cpu_used = 0;
        clr_start = 1;
        tick();
        clr_start = 0;
        for (int i = 0; i < 12; i++) begin
            cpu_req = m_clear && m_idx == 4 && !cpu_used;
            cpu_dr = 3'd6; cpu_data = 16'hCAFE;
            if (cpu_req) cpu_used = 1;
            tick();
        end
        cpu_req = 0;
        chk("clr_cpu_writes", wr_cnt,    32'd9);
        chk("clr_cpu_slot",   wr_log[4], 32'd6);
        chk("clr_resume",     wr_log[5], 32'd4);
        chk("clr_cpu_done",   done_cnt,  32'd1);

        // Reset in the middle of a clear.
        clr_start = 1;
        tick();
        clr_start = 0;
        guard = 0;
        while (m_idx != 2 && guard < 10) begin tick(); guard++; end
        chk("mid_clr_reached", m_idx, 32'd2);
        Reset = 1'b0;
        #1 check_all_zero("mid_reset");
        model_reset();
        @(negedge Clk);
        Reset = 1'b1;
        clear_counters();
        repeat (12) tick();
        chk("post_reset_done", done_cnt, 32'd0);
        chk("post_reset_busy", busy_cnt, 32'd0);

        // Randomized traffic obeying the request protocols.
        dbg_linger = 0;
        for (int c = 0; c < 600; c++) begin
            if (!last_stall) begin
                cpu_req  = ($urandom_range(0, 99) < 40);
                cpu_dr   = 3'($urandom_range(0, 7));
                cpu_data = 16'($urandom);
            end
            if (dbg_linger) begin
                dbg_req = 0; dbg_linger = 0;
            end else if (dbg_req) begin
                if (m_ack) begin
                    if ($urandom_range(0, 1) == 1) dbg_linger = 1;
                    else dbg_req = 0;
                end
            end else if ($urandom_range(0, 99) < 20) begin
                dbg_req  = 1;
                dbg_dr   = 3'($urandom_range(0, 7));
                dbg_data = 16'($urandom);
            end
            clr_start = ($urandom_range(0, 99) < 3);
            tick();
        end

        idle_inputs();
        repeat (12) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port cpu_req, input, 1 bit: CPU writeback request, one-cycle, never back-pressured except via cpu_stall.
REQ-004 SHALL have ports cpu_dr, input, 3 bits, and cpu_data, input, 16 bits: CPU destination register and write value.
REQ-005 SHALL have port dbg_req, input, 1 bit: debug-host write request, held high until dbg_ack.
REQ-006 SHALL have ports dbg_dr, input, 3 bits, and dbg_data, input, 16 bits: debug destination and value, stable while dbg_req is high.
REQ-007 SHALL have port clr_start, input, 1 bit: one-cycle pulse requesting zeroing of R0..R7.
REQ-008 SHALL have ports LD_REG, output, 1 bit; DR, output, 3 bits; wr_data, output, 16 bits: registered register-file write port.
REQ-009 SHALL have port dbg_ack, output, 1 bit: registered one-cycle pulse, coincident with the LD_REG cycle of the debug write.
REQ-010 SHALL have port cpu_stall, output, 1 bit: combinational; high in a cycle where a pending cpu_req is not granted.
REQ-011 SHALL have ports clr_busy, output, 1 bit (high in CLEAR), and clr_done, output, 1 bit (registered one-cycle pulse).

Function
REQ-012 SHALL implement states IDLE and CLEAR, a 3-bit clear index clr_idx and a 2-bit saturating starvation counter wait_cnt.
REQ-013 SHALL resolve at most one grant per cycle; the granted write appears on LD_REG/DR/wr_data in the next cycle (latency 1); LD_REG=0 when nothing is granted, with DR/wr_data holding their last values.
REQ-014 SHALL, in IDLE, grant: debug if dbg_req and wait_cnt==3; else CPU if cpu_req; else debug if dbg_req.
REQ-015 SHALL NOT grant debug in a cycle where dbg_ack is high, preventing a double write of one request.
REQ-016 SHALL, in IDLE, increment wait_cnt (saturating at 3) in each cycle dbg_req is high and debug is not granted, and clear it to 0 on a debug grant or when dbg_req is low.
REQ-017 SHALL assert cpu_stall only when cpu_req is high and debug wins by starvation; the stalled CPU re-presents the request.
REQ-018 SHALL, on clr_start in IDLE, enter CLEAR with clr_idx=0 in the next cycle; cpu/dbg arbitration in that same cycle proceeds per REQ-014.
REQ-019 SHALL, in CLEAR, grant a clear write (DR=clr_idx, wr_data=16'h0000) in each cycle without cpu_req, then increment clr_idx.
REQ-020 SHALL give cpu_req priority over the clear write in CLEAR; clr_idx holds that cycle and cpu_stall stays 0.
REQ-021 SHALL never grant debug in CLEAR; wait_cnt holds its value throughout CLEAR.
REQ-022 SHALL, on granting the clear write at clr_idx=7, return to IDLE and pulse clr_done in the following cycle, coincident with the R7 LD_REG.
REQ-023 SHALL ignore clr_start while in CLEAR.

Reset
REQ-024 SHALL, while Reset=0, force IDLE, clr_idx=0, wait_cnt=0, LD_REG=0, DR=0, wr_data=0, dbg_ack=0, clr_done=0, clr_busy=0, independent of Clk.
REQ-025 SHALL, on reset mid-CLEAR, abort the sequence with no clr_done pulse, and require a fresh clr_start afterwards.

Verification
REQ-026 SHALL cover: cpu_req, cpu_dr=3, cpu_data=16'hBEEF at cycle N -> LD_REG=1, DR=3, wr_data=16'hBEEF at N+1 only.
REQ-027 SHALL cover: dbg_req, dbg_dr=5, dbg_data=16'h1234 with cpu idle -> one write, dbg_ack pulsed exactly once, no repeat while dbg_req is still high in the ack cycle.
REQ-028 SHALL cover: cpu_req continuously high with dbg_req high -> three CPU grants, then a debug grant with cpu_stall=1 in that cycle, then CPU resumes.
REQ-029 SHALL cover: clr_start with no other traffic -> clr_busy for 8 cycles, writes of 0 to DR=0..7 in order, clr_done pulsed with the DR=7 write.
REQ-030 SHALL cover: cpu_req at clr_idx=4 during CLEAR -> CPU write, then clear resumes at DR=4; total of 9 write cycles.
REQ-031 SHALL cover: Reset low at clr_idx=2 -> all outputs 0 immediately, state IDLE, and no clr_done after release.
